// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared types and constants for the divider-sharing arbiter
package div_share_pkg;

  localparam int LOCK_MAX    = 256;
  localparam int LOCK_CNT_W  = $clog2(LOCK_MAX);
  localparam int OWNER_W     = 2;
  localparam int TAG_NUMER_W = 64;

  localparam logic [63:0] DIV0_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                   valid;
    logic [OWNER_W-1:0]     owner;
    logic                   div0;
    logic [TAG_NUMER_W-1:0] numer;
  } tag_t;

  function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - request/response/divider bundle of the divider-sharing arbiter
interface div_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 64
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ-1:0][W-1:0] req_numer;
  logic [N_REQ-1:0][W-1:0] req_denom;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [W-1:0]            resp_quotient;
  logic [W-1:0]            resp_remain;
  logic                    resp_div0;
  logic [W-1:0]            div_numer;
  logic [W-1:0]            div_denom;
  logic [W-1:0]            div_quotient;
  logic [W-1:0]            div_remain;
  logic                    busy;

  modport master (
    output req_valid, req_lock, req_numer, req_denom, div_quotient, div_remain,
    input  req_ready, resp_valid, resp_quotient, resp_remain, resp_div0,
           div_numer, div_denom, busy
  );

  modport slave (
    input  req_valid, req_lock, req_numer, req_denom, div_quotient, div_remain,
    output req_ready, resp_valid, resp_quotient, resp_remain, resp_div0,
           div_numer, div_denom, busy
  );
endinterface

// File: rtl/div_share_arbiter_rr_grant.sv
// rtl/div_share_arbiter_rr_grant.sv - round-robin one-hot grant starting at the pointer, with wrap
module rr_grant
  import div_share_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [OWNER_W-1:0] ptr_i,
  input  logic [N-1:0]       req_i,
  output logic [N-1:0]       grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && req_i[j]) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - shares one pipelined divider between N_REQ requesters with RR + burst lock
// Optional per-requester grant and stall counters: DIV_SHARE_ARB_STATS_EN.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DIV_LATENCY = 2,
  parameter int W           = 64
) (
  input  logic clk,
  input  logic reset,
  div_share_arbiter_if.slave bus
`ifdef DIV_SHARE_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0] stat_grants,
  output logic [31:0]            stat_stall
`endif
);

  localparam int L = DIV_LATENCY;

  arb_state_e              state_q, state_d;
  logic [OWNER_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0]      lock_owner_q, lock_owner_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0]        rr_gnt, grant, accept_vec, lock_onehot, resp_vec;
  logic [OWNER_W-1:0]      winner;
  logic [W-1:0]            sel_numer, sel_denom;
  logic                    accept, is_div0, winner_lock, owner_lock;
  tag_t                    tag_q [L+1];
  logic [W-1:0]            div_numer_q, div_denom_q, resp_quot_q, resp_rem_q;
  logic [N_REQ-1:0]        resp_valid_q;
  logic                    resp_div0_q;

  rr_grant #(.N(N_REQ)) u_rr_grant (
    .ptr_i   (rr_ptr_q),
    .req_i   (bus.req_valid),
    .grant_o (rr_gnt)
  );

  // Output process: a held lock overrides round robin; ready is forced low in reset.
  always_comb begin
    lock_onehot = '0;
    for (int i = 0; i < N_REQ; i++) lock_onehot[i] = (OWNER_W'(i) == lock_owner_q);
    grant = (state_q == ARB_LOCKED) ? (lock_onehot & bus.req_valid) : rr_gnt;
    if (reset) grant = '0;
  end

  assign bus.req_ready = grant;
  assign accept_vec    = grant & bus.req_valid;
  assign accept        = |accept_vec;
  assign winner_lock   = |(accept_vec & bus.req_lock);
  assign owner_lock    = |(lock_onehot & bus.req_lock);
  assign is_div0       = accept && (sel_denom == '0);

  always_comb begin
    winner    = '0;
    sel_numer = '0;
    sel_denom = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept_vec[i]) begin
        winner    = OWNER_W'(i);
        sel_numer = bus.req_numer[i];
        sel_denom = bus.req_denom[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (accept) rr_ptr_d = wrap_inc(winner, N_REQ);
    case (state_q)
      ARB_IDLE: begin
        if (accept && winner_lock) begin
          state_d      = ARB_LOCKED;
          lock_owner_d = winner;
          lock_cnt_d   = '0;
        end
      end
      ARB_LOCKED: begin
        // Starvation guard takes precedence over a still-asserted lock.
        if (lock_cnt_q == LOCK_CNT_W'(LOCK_MAX - 1)) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = wrap_inc(lock_owner_q, N_REQ);
        end else if (!owner_lock) begin
          state_d = ARB_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      resp_vec[i] = tag_q[L].valid && (tag_q[L].owner == OWNER_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= L; i++) tag_q[i] <= '0;
      div_numer_q  <= '0;
      div_denom_q  <= W'(1);
      resp_valid_q <= '0;
      resp_quot_q  <= '0;
      resp_rem_q   <= '0;
      resp_div0_q  <= 1'b0;
    end else begin
      tag_q[0].valid <= accept;
      tag_q[0].owner <= winner;
      tag_q[0].div0  <= is_div0;
      tag_q[0].numer <= is_div0 ? TAG_NUMER_W'(sel_numer) : '0;
      for (int i = 1; i <= L; i++) tag_q[i] <= tag_q[i-1];
      if (accept) begin
        div_numer_q <= is_div0 ? '0 : sel_numer;
        div_denom_q <= is_div0 ? W'(1) : sel_denom;
      end
      resp_valid_q <= resp_vec;
      resp_div0_q  <= tag_q[L].valid && tag_q[L].div0;
      if (tag_q[L].valid) begin
        resp_quot_q <= tag_q[L].div0 ? W'(DIV0_QUOTIENT) : bus.div_quotient;
        resp_rem_q  <= tag_q[L].div0 ? W'(tag_q[L].numer) : bus.div_remain;
      end
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i <= L; i++) bus.busy = bus.busy | tag_q[i].valid;
  end

  assign bus.div_numer     = div_numer_q;
  assign bus.div_denom     = div_denom_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_quotient = resp_quot_q;
  assign bus.resp_remain   = resp_rem_q;
  assign bus.resp_div0     = resp_div0_q;

`ifdef DIV_SHARE_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] stat_grants_q;
  logic [31:0]            stat_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (accept_vec[i]) stat_grants_q[i] <= stat_grants_q[i] + 32'd1;
      if ((|(bus.req_valid & ~accept_vec)) && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - directed self-checking bench for div_share_arbiter
module tb_div_share_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int cyc;
    int who;
  } acc_t;

  typedef struct {
    int          cyc;
    int          who;
    logic [63:0] q;
    logic [63:0] r;
    logic        d0;
  } rsp_t;

  acc_t acc_log[$];
  rsp_t rsp_log[$];

  div_share_arbiter_if #(.N_REQ(2), .W(64)) bus ();

`ifdef DIV_SHARE_ARB_STATS_EN
  logic [1:0][31:0] stat_grants;
  logic [31:0]      stat_stall;
`endif

  div_share_arbiter #(.N_REQ(2), .DIV_LATENCY(2), .W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DIV_SHARE_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage divider IP model
  logic [63:0] dq1, dr1;
  always @(posedge clk) begin
    if (bus.div_denom != 64'd0) begin
      dq1 <= bus.div_numer / bus.div_denom;
      dr1 <= bus.div_numer % bus.div_denom;
    end else begin
      dq1 <= 64'd0;
      dr1 <= 64'd0;
    end
    bus.div_quotient <= dq1;
    bus.div_remain   <= dr1;
  end

  acc_t a_ev;
  rsp_t r_ev;
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          a_ev.cyc = cyc;
          a_ev.who = i;
          acc_log.push_back(a_ev);
        end
        if (bus.resp_valid[i]) begin
          r_ev.cyc = cyc;
          r_ev.who = i;
          r_ev.q   = bus.resp_quotient;
          r_ev.r   = bus.resp_remain;
          r_ev.d0  = bus.resp_div0;
          rsp_log.push_back(r_ev);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 64) begin
      tick(1);
      n++;
    end
    check("drain_busy", 64'(bus.busy), 64'd0);
    tick(2);
  endtask

  // Each response must follow its accept by 4 cycles and go back to the same requester.
  task automatic check_order(input string tag);
    check({tag, "_nresp"}, 64'(rsp_log.size()), 64'(acc_log.size()));
    for (int i = 0; i < acc_log.size() && i < rsp_log.size(); i++) begin
      if (i < 8 || rsp_log[i].cyc - acc_log[i].cyc != 4 || rsp_log[i].who != acc_log[i].who) begin
        check({tag, "_lat"}, 64'(rsp_log[i].cyc - acc_log[i].cyc), 64'd4);
        check({tag, "_who"}, 64'(rsp_log[i].who), 64'(acc_log[i].who));
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first1;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_numer = '0;
    bus.req_denom = '0;
    tick(2);

    bus.req_valid = 2'b11;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_div_denom", bus.div_denom, 64'd1);
    check("rst_div_numer", bus.div_numer, 64'd0);
    check("rst_quotient", bus.resp_quotient, 64'd0);
    bus.req_valid = '0;
    tick(1);
    reset = 1'b0;
    tick(1);

    // single request 100/7
    clear_logs();
    bus.req_numer[0] = 64'd100;
    bus.req_denom[0] = 64'd7;
    bus.req_valid    = 2'b01;
    tick(1);
    check("single_denom_reg", bus.div_denom, 64'd7);
    bus.req_valid = 2'b00;
    wait_idle();
    check("single_nacc", 64'(acc_log.size()), 64'd1);
    check_order("single");
    if (rsp_log.size() >= 1) begin
      check("single_q", rsp_log[0].q, 64'd14);
      check("single_r", rsp_log[0].r, 64'd2);
      check("single_div0", 64'(rsp_log[0].d0), 64'd0);
    end

    // requester 1 locks across 5 accepts (lock released on the 5th) while requester 0 waits
    clear_logs();
    bus.req_numer[0] = 64'd70;
    bus.req_denom[0] = 64'd6;
    bus.req_numer[1] = 64'd50;
    bus.req_denom[1] = 64'd5;
    bus.req_valid    = 2'b11;
    bus.req_lock     = 2'b10;
    tick(4);
    bus.req_lock = 2'b00;
    tick(1);
    bus.req_valid = 2'b01;
    tick(1);
    bus.req_valid = 2'b00;
    wait_idle();
    check("lock_nacc", 64'(acc_log.size()), 64'd6);
    if (acc_log.size() >= 6) begin
      for (int i = 0; i < 5; i++) check("lock_who1", 64'(acc_log[i].who), 64'd1);
      check("lock_who0", 64'(acc_log[5].who), 64'd0);
      check("lock_stall", 64'(acc_log[5].cyc - acc_log[0].cyc), 64'd5);
    end
    check_order("lock");
    if (rsp_log.size() >= 6) begin
      check("lock_q1", rsp_log[0].q, 64'd10);
      check("lock_q0", rsp_log[5].q, 64'd11);
      check("lock_r0", rsp_log[5].r, 64'd4);
    end

    // divide by zero on requester 1
    clear_logs();
    bus.req_numer[1] = 64'h1234;
    bus.req_denom[1] = 64'd0;
    bus.req_valid    = 2'b10;
    tick(1);
    bus.req_valid = 2'b00;
    check("div0_denom_reg", bus.div_denom, 64'd1);
    check("div0_numer_reg", bus.div_numer, 64'd0);
    wait_idle();
    check_order("div0");
    if (rsp_log.size() >= 1) begin
      check("div0_q", rsp_log[0].q, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div0_r", rsp_log[0].r, 64'h1234);
      check("div0_flag", 64'(rsp_log[0].d0), 64'd1);
    end

    // contention, no lock: grants alternate starting at requester 0
    clear_logs();
    bus.req_numer[0] = 64'd1000;
    bus.req_denom[0] = 64'd10;
    bus.req_numer[1] = 64'd999;
    bus.req_denom[1] = 64'd3;
    bus.req_valid    = 2'b11;
    tick(4);
    bus.req_valid = 2'b00;
    wait_idle();
    check("cont_nacc", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++) begin
      check("cont_who", 64'(acc_log[i].who), 64'(i % 2));
      check("cont_b2b", 64'(acc_log[i].cyc - acc_log[0].cyc), 64'(i));
    end
    check_order("cont");
    for (int i = 0; i < rsp_log.size() && i < 4; i++) begin
      check("cont_q", rsp_log[i].q, (i % 2 == 1) ? 64'd333 : 64'd100);
      check("cont_r", rsp_log[i].r, 64'd0);
    end

    // starvation guard: requester 0 holds lock, requester 1 waits
    clear_logs();
    bus.req_numer[0] = 64'd9;
    bus.req_denom[0] = 64'd3;
    bus.req_numer[1] = 64'd8;
    bus.req_denom[1] = 64'd2;
    bus.req_valid    = 2'b11;
    bus.req_lock     = 2'b01;
    tick(300);
    bus.req_valid = 2'b00;
    bus.req_lock  = 2'b00;
    wait_idle();
    first1 = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (first1 < 0 && acc_log[i].who == 1) first1 = i;
    check("starve_first1_idx", 64'(first1), 64'd257);
    if (first1 >= 0)
      check("starve_first1_cyc", 64'(acc_log[first1].cyc - acc_log[0].cyc), 64'd257);
    check_order("starve");

    // reset with three operations in flight
    clear_logs();
    bus.req_numer[0] = 64'd100;
    bus.req_denom[0] = 64'd7;
    bus.req_valid    = 2'b01;
    tick(3);
    bus.req_valid = 2'b00;
    check("mid_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_busy_in_rst", 64'(bus.busy), 64'd0);
    check("mid_denom_in_rst", bus.div_denom, 64'd1);
    tick(1);
    reset = 1'b0;
    tick(8);
    check("mid_nresp", 64'(rsp_log.size()), 64'd0);
    check("mid_busy_after", 64'(bus.busy), 64'd0);
    check("mid_denom_after", bus.div_denom, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
